// File: rtl/csc_pkg.sv
// Shared constants for the RGB888 -> BT.709 YCbCr 4:2:2 converter.
// Define CSC_FULL_RANGE_EN to select full-range coefficients and blank luma.
package csc_pkg;

    localparam int LATENCY = 4;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

`ifdef CSC_FULL_RANGE_EN
    localparam logic signed [8:0] KY_R  =  9'sd54;
    localparam logic signed [8:0] KY_G  =  9'sd183;
    localparam logic signed [8:0] KY_B  =  9'sd19;
    localparam logic signed [8:0] KCB_R = -9'sd29;
    localparam logic signed [8:0] KCB_G = -9'sd99;
    localparam logic signed [8:0] KCB_B =  9'sd128;
    localparam logic signed [8:0] KCR_R =  9'sd128;
    localparam logic signed [8:0] KCR_G = -9'sd116;
    localparam logic signed [8:0] KCR_B = -9'sd12;
    localparam int                Y_OFS = 0;
    localparam logic [7:0]        BLANK_Y = 8'h00;
`else
    localparam logic signed [8:0] KY_R  =  9'sd47;
    localparam logic signed [8:0] KY_G  =  9'sd157;
    localparam logic signed [8:0] KY_B  =  9'sd16;
    localparam logic signed [8:0] KCB_R = -9'sd26;
    localparam logic signed [8:0] KCB_G = -9'sd86;
    localparam logic signed [8:0] KCB_B =  9'sd112;
    localparam logic signed [8:0] KCR_R =  9'sd112;
    localparam logic signed [8:0] KCR_G = -9'sd102;
    localparam logic signed [8:0] KCR_B = -9'sd10;
    localparam int                Y_OFS = 16;
    localparam logic [7:0]        BLANK_Y = 8'h10;
`endif

    localparam int         C_OFS   = 128;
    localparam logic [7:0] BLANK_C = 8'h80;

    function automatic logic [7:0] clamp8(input logic signed [10:0] v);
        if (v < 0)
            return 8'h00;
        else if (v > 11'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/rgb888_to_ycbcr422_if.sv
// Video bus between the pattern generator (master) and the converter (slave).
interface rgb888_to_ycbcr422_if;

    logic       i_hs;
    logic       i_vs;
    logic       i_de;
    logic [7:0] i_r;
    logic [7:0] i_g;
    logic [7:0] i_b;
    logic       o_hs;
    logic       o_vs;
    logic       o_de;
    logic [7:0] o_y;
    logic [7:0] o_c;

    modport master (
        output i_hs, i_vs, i_de, i_r, i_g, i_b,
        input  o_hs, o_vs, o_de, o_y, o_c
    );

    modport slave (
        input  i_hs, i_vs, i_de, i_r, i_g, i_b,
        output o_hs, o_vs, o_de, o_y, o_c
    );

endinterface

// File: rtl/csc_mac.sv
// One colour channel: 3 products, sum, round/offset/clamp; 3 registered stages.
module csc_mac
    import csc_pkg::*;
#(
    parameter logic signed [8:0] K_R = '0,
    parameter logic signed [8:0] K_G = '0,
    parameter logic signed [8:0] K_B = '0,
    parameter int                OFS = 0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] q
);

    logic signed [17:0] p_r, p_g, p_b;
    logic signed [17:0] sum;
    logic signed [17:0] rnd;
    logic signed [10:0] v;

    // Arithmetic shift floors, so negative chroma sums round consistently.
    always_comb begin
        rnd = sum + 18'sd128;
        v   = 11'(rnd >>> 8) + 11'(OFS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
            sum <= '0;
            q   <= '0;
        end else begin
            p_r <= 18'($signed({1'b0, r})) * 18'(K_R);
            p_g <= 18'($signed({1'b0, g})) * 18'(K_G);
            p_b <= 18'($signed({1'b0, b})) * 18'(K_B);
            sum <= p_r + p_g + p_b;
            q   <= clamp8(v);
        end
    end

endmodule

// File: rtl/rgb888_to_ycbcr422.sv
// RGB888 -> BT.709 YCbCr 4:2:2, 4 clk latency, co-sited chroma.
// Build with CSC_FULL_RANGE_EN for full-range output (see csc_pkg).
module rgb888_to_ycbcr422
    import csc_pkg::*;
#(
    parameter bit C_FIRST  = 1'b0,
    parameter bit BLANK_EN = 1'b1
)(
    input logic                  clk,
    input logic                  rst,
    rgb888_to_ycbcr422_if.slave  bus
);

    sync_t               sync_in;
    sync_t [LATENCY:1]   sync_pipe;

    logic [7:0] y3, cb3, cr3;
    logic [7:0] y_q, c_q, c_hold;
    logic       phase;
    logic       de3, de4, cur_phase;

    assign sync_in = '{hs: bus.i_hs, vs: bus.i_vs, de: bus.i_de};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[LATENCY-1:1], sync_in};
    end

    csc_mac #(.K_R(KY_R),  .K_G(KY_G),  .K_B(KY_B),  .OFS(Y_OFS)) u_y (
        .clk(clk), .rst(rst), .r(bus.i_r), .g(bus.i_g), .b(bus.i_b), .q(y3)
    );
    csc_mac #(.K_R(KCB_R), .K_G(KCB_G), .K_B(KCB_B), .OFS(C_OFS)) u_cb (
        .clk(clk), .rst(rst), .r(bus.i_r), .g(bus.i_g), .b(bus.i_b), .q(cb3)
    );
    csc_mac #(.K_R(KCR_R), .K_G(KCR_G), .K_B(KCR_B), .OFS(C_OFS)) u_cr (
        .clk(clk), .rst(rst), .r(bus.i_r), .g(bus.i_g), .b(bus.i_b), .q(cr3)
    );

    assign de3 = sync_pipe[LATENCY-1].de;
    assign de4 = sync_pipe[LATENCY].de;

    // A de rising edge at S4 restarts the line at the configured chroma phase.
    assign cur_phase = (de3 && !de4) ? C_FIRST : phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            c_q    <= '0;
            c_hold <= '0;
            phase  <= C_FIRST;
        end else if (de3) begin
            y_q   <= y3;
            phase <= ~cur_phase;
            if (cur_phase == C_FIRST) begin
                c_q    <= C_FIRST ? cr3 : cb3;
                c_hold <= C_FIRST ? cb3 : cr3;
            end else begin
                c_q <= c_hold;
            end
        end else if (BLANK_EN) begin
            y_q <= BLANK_Y;
            c_q <= BLANK_C;
        end
    end

    assign bus.o_hs = sync_pipe[LATENCY].hs;
    assign bus.o_vs = sync_pipe[LATENCY].vs;
    assign bus.o_de = de4;
    assign bus.o_y  = y_q;
    assign bus.o_c  = c_q;

endmodule

// File: tb/tb_rgb888_to_ycbcr422.sv
// Self-checking bench for rgb888_to_ycbcr422 (default parameters).
module tb_rgb888_to_ycbcr422;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rgb888_to_ycbcr422_if bus();
    rgb888_to_ycbcr422 dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CSC_FULL_RANGE_EN
    localparam int M_YR = 54,  M_YG = 183,  M_YB = 19,  M_YOFS = 0;
    localparam int M_BR = -29, M_BG = -99,  M_BB = 128;
    localparam int M_RR = 128, M_RG = -116, M_RB = -12;
    localparam logic [7:0] M_BLANK_Y = 8'h00;
`else
    localparam int M_YR = 47,  M_YG = 157,  M_YB = 16,  M_YOFS = 16;
    localparam int M_BR = -26, M_BG = -86,  M_BB = 112;
    localparam int M_RR = 112, M_RG = -102, M_RB = -10;
    localparam logic [7:0] M_BLANK_Y = 8'h10;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] y;
        logic [7:0] c;
    } exp_t;

    exp_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         pos      = 0;
    logic       prev_de  = 1'b0;
    logic [7:0] held_cr  = 8'h00;
    int         de_cnt   = 0;

    function automatic logic [7:0] model_csc(input int kr, input int kg, input int kb,
                                             input int ofs, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b);
        int ri, gi, bi, v;
        ri = r; gi = g; bi = b;
        v = ofs + ((kr * ri + kg * gi + kb * bi + 128) >>> 8);
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, advance one clock, compare outputs with the pixel 4 clocks back.
    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        bus.i_hs = hs; bus.i_vs = vs; bus.i_de = de;
        bus.i_r  = r;  bus.i_g  = g;  bus.i_b  = b;
        e.hs = hs; e.vs = vs; e.de = de;
        if (de) begin
            if (!prev_de) pos = 0;
            e.y = model_csc(M_YR, M_YG, M_YB, M_YOFS, r, g, b);
            if (pos % 2 == 0) begin
                e.c     = model_csc(M_BR, M_BG, M_BB, 128, r, g, b);
                held_cr = model_csc(M_RR, M_RG, M_RB, 128, r, g, b);
            end else begin
                e.c = held_cr;
            end
            pos++;
        end else begin
            e.y = M_BLANK_Y;
            e.c = 8'h80;
        end
        prev_de = de;
        exp_q.push_back(e);
        @(negedge clk);
        if (bus.o_de) de_cnt++;
        if (exp_q.size() >= 4) e = exp_q[exp_q.size() - 4];
        else                   e = {3'b000, M_BLANK_Y, 8'h80};
        chk("o_hs", 32'(bus.o_hs), 32'(e.hs));
        chk("o_vs", 32'(bus.o_vs), 32'(e.vs));
        chk("o_de", 32'(bus.o_de), 32'(e.de));
        chk("o_y",  32'(bus.o_y),  32'(e.y));
        chk("o_c",  32'(bus.o_c),  32'(e.c));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step(1'b0, 1'b0, 1'b1, r, g, b);
    endtask

    task automatic rand_line(input int len);
        for (int i = 0; i < len; i++) pix(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Assert reset mid-cycle, check outputs clear without a clock, release on a negedge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_o_hs", 32'(bus.o_hs), 32'h0);
        chk("rst_o_vs", 32'(bus.o_vs), 32'h0);
        chk("rst_o_de", 32'(bus.o_de), 32'h0);
        chk("rst_o_y",  32'(bus.o_y),  32'h0);
        chk("rst_o_c",  32'(bus.o_c),  32'h0);
        exp_q.delete();
        prev_de = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_hs = 1'b0; bus.i_vs = 1'b0; bus.i_de = 1'b0;
        bus.i_r  = 8'h00; bus.i_g = 8'h00; bus.i_b = 8'h00;
        do_reset();

        // Black then white lines.
        idle(2);
        for (int i = 0; i < 8; i++) pix(8'h00, 8'h00, 8'h00);
        idle(2);
        for (int i = 0; i < 8; i++) pix(8'hFF, 8'hFF, 8'hFF);
        idle(3);

        // Red pair, then red/blue co-siting.
        pix(8'hFF, 8'h00, 8'h00); pix(8'hFF, 8'h00, 8'h00);
        idle(2);
        pix(8'hFF, 8'h00, 8'h00); pix(8'h00, 8'h00, 8'hFF);
        idle(2);

        // Odd-length line, next line, single-cycle de.
        rand_line(3);
        idle(1);
        rand_line(2);
        idle(2);
        rand_line(1);
        idle(3);

        // Scaled frame: 4 lines x 16 active, hs in blank, vs on the first line.
        idle(4);
        de_cnt = 0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int h = 0; h < 6; h++)
                step(h >= 1 && h <= 2, ln == 0, 1'b0, 8'h00, 8'h00, 8'h00);
            rand_line(16);
        end
        idle(4);
        chk("frame_de_count", 32'(de_cnt), 32'd64);

        // Random lines with random blanking and sync.
        for (int ln = 0; ln < 30; ln++) begin
            int gap = $urandom_range(1, 3);
            for (int i = 0; i < gap; i++)
                step(1'($urandom), 1'($urandom), 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            rand_line($urandom_range(1, 9));
        end

        // Reset in the middle of a line; the line continues after release.
        idle(2);
        rand_line(3);
        do_reset();
        rand_line(5);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb888_to_ycbcr422.md
Name: rgb888_to_ycbcr422

Overview:
Pipelined colour-space converter that sits directly downstream of the 1080p60 timing/pattern generator. It converts RGB888 pixels, qualified by hs/vs/de, into BT.709 YCbCr 4:2:2 (16-bit Y + C) for the HDMI transmitter input bus. Sync and data-enable are delayed to stay aligned with the converted data. Fixed latency: 4 clk.

Parameters:
C_FIRST, 0, chroma phase at the first active pixel of each line: 0 = Cb first, 1 = Cr first
BLANK_EN, 1, 1 = drive blank codes on o_y/o_c while o_de=0; 0 = hold the last active values

Ports:
clk  in  1  pixel clock, 148.5 MHz for 1080p60
rst  in  1  asynchronous reset, active-high
i_hs  in  1  horizontal sync, active-high
i_vs  in  1  vertical sync, active-high
i_de  in  1  active-video qualifier
i_r  in  8  red
i_g  in  8  green
i_b  in  8  blue
o_hs  out  1  i_hs delayed by 4 clk
o_vs  out  1  i_vs delayed by 4 clk
o_de  out  1  i_de delayed by 4 clk
o_y  out  8  luma
o_c  out  8  chroma, alternating Cb/Cr

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the only clock. All pipeline registers clear on rst.
- Reset values: o_hs=0, o_vs=0, o_de=0, o_y=0x00, o_c=0x00, chroma phase=C_FIRST.
- Sync pipeline: hs/vs/de shift through 4 stages; no edge is dropped or reshaped.
- Pipeline stages:
  - S1 registers 9 signed products (8b unsigned x 9b signed coefficient).
  - S2 registers the three sums (18b signed).
  - S3 adds rounding constant 128, arithmetic shift right 8, adds offset, clamps to 0..255.
  - S4 performs 4:2:2 selection and blanking.
- Coefficients, limited range (default):
  - Y = 16 + (47R + 157G + 16B)
  - Cb = 128 + (-26R - 86G + 112B)
  - Cr = 128 + (112R - 102G - 10B)
  - Each bracketed sum is rounded and shifted as in S3.
- Chroma subsampling is co-sited:
  - The even pixel outputs Cb(even). Its Cr(even) is held in a register and output on the following odd pixel.
  - The Cr/Cb of odd pixels are discarded.
  - With C_FIRST=1 the roles swap.
- Phase toggles every cycle in which the S4 de is high. Phase resets to C_FIRST on every de rising edge, so each line restarts at Cb.
- Odd-length line: the final pixel emits its even-phase chroma only; the next line still starts at C_FIRST.
- Blanking (BLANK_EN=1): while S4 de=0, o_y=0x10 and o_c=0x80. Under CSC_FULL_RANGE_EN, o_y=0x00 and o_c=0x80.
- de high for one cycle: treated as a one-pixel line, so it emits Y plus Cb.
- Inputs are sampled only on clk; no backpressure, no handshake, one pixel per cycle always.
- rst asserted mid-frame: outputs go to reset values immediately (asynchronously). After release, o_de stays 0 for at least 4 clk, until valid i_de propagates.

Optional Feature:
- Macro CSC_FULL_RANGE_EN.
- Defined: full-range BT.709 coefficients.
  - Y = 54R + 183G + 19B, no offset
  - Cb = 128 + (-29R - 99G + 128B)
  - Cr = 128 + (128R - 116G - 12B)
  - Same rounding, shift and clamp as limited range. Blank luma becomes 0x00.
- Undefined: limited-range coefficients and 16/128 offsets as above.

Decomposition:
- Package csc_pkg holds:
  - both coefficient sets as signed 9b localparams, selected by CSC_FULL_RANGE_EN inside the package;
  - offsets Y_OFS and C_OFS;
  - blank codes;
  - LATENCY=4.
- Sub-module csc_mac: one channel, three multiplies, sum, round/offset/clamp, 3-stage registered. Instantiated three times (Y, Cb, Cr). The top level owns the sync delay line, chroma phase and S4 mux.

Test Plan:
- Black then white (limited range), de high for 8 pixels:
  - black (0,0,0) -> Y=0x10, C alternates 0x80/0x80;
  - white (255,255,255) -> Y=0xEB, C=0x80/0x80;
  - first valid o_de exactly 4 clk after i_de.
- Red pair (255,0,0),(255,0,0) -> Y=0x3F,0x3F; C=0x66 (Cb) then 0xF0 (Cr).
- Co-siting: pixel0 red, pixel1 blue (0,0,255) -> o_c second sample = Cr(red)=0xF0, not Cr(blue). Blue Y = 0x20.
- Line phase: line of 3 pixels then a new de rise -> C order Cb,Cr,Cb then Cb on the next line. A 1-cycle de emits Cb. Blanking gives 0x10/0x80.
- 1920x1080 timing from the pattern generator:
  - o_hs/o_vs/o_de equal the inputs shifted by exactly 4 clk across a full frame;
  - count of o_de cycles = 2,073,600.
- Reset mid-line: rst pulsed during de -> outputs go to 0 asynchronously; after release o_de=0 for ≥4 clk; the next line starts at phase Cb. With CSC_FULL_RANGE_EN, white -> Y=0xFF, C=0x80; black -> Y=0x00.
